// File: rtl/input_stream_packer_pkg.sv
// Shared load/store path types: FSM state enums and the width-ratio check used by
// the narrow-to-wide packer and the wide-to-narrow splitter.
package input_stream_packer_pkg;

  typedef enum logic {FILL, DRAIN} packer_state_t;

  typedef enum logic {LOAD, EMIT} splitter_state_t;

  // Narrow width must be whole bytes and divide the wide width at least twice.
  function automatic bit width_ratio_ok(input int unsigned bw_narrow,
                                        input int unsigned bw_wide);
    if (bw_narrow == 0) return 1'b0;
    if (bw_narrow % 8 != 0) return 1'b0;
    if (bw_wide % bw_narrow != 0) return 1'b0;
    return (bw_wide / bw_narrow) >= 2;
  endfunction

endpackage

// File: rtl/input_stream_packer_if.sv
// HWPE stream interface: data with byte strobes under a valid/ready handshake.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DataWidth = 32
);
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   valid;
    logic                   ready;

    modport source (output data, output strb, output valid, input ready);
    modport sink   (input data, input strb, input valid, output ready);
    modport master (output data, output strb, output valid, input ready);
    modport slave  (input data, input strb, input valid, output ready);
endinterface

// File: rtl/input_stream_packer.sv
// Narrow-to-wide stream packer: gathers N narrow beats LSB-first into one wide word,
// with an optional flush that closes a partially filled word.
module input_stream_packer
  import input_stream_packer_pkg::*;
#(
    parameter int unsigned BW_IN  = 32,
    parameter int unsigned BW_OUT = 128
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          flush_i,
    hwpe_stream_intf_stream.sink          stream_i,
    hwpe_stream_intf_stream.source        stream_o
);

    localparam int unsigned N     = BW_OUT / BW_IN;
    localparam int unsigned CntW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SbIn  = BW_IN / 8;
    localparam int unsigned SbOut = BW_OUT / 8;

    if (!width_ratio_ok(BW_IN, BW_OUT)) begin : g_bad_width
        $error("input_stream_packer: invalid BW_IN/BW_OUT ratio");
    end

    packer_state_t     state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BW_OUT-1:0] buf_q, buf_d;
    logic [SbOut-1:0]  strb_q, strb_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        buf_d          = buf_q;
        strb_d         = strb_q;
        stream_i.ready = 1'b1;

        unique case (state_q)
            FILL: begin
                if (stream_i.valid) begin
                    buf_d[cnt_q*BW_IN +: BW_IN] = stream_i.data;
                    strb_d[cnt_q*SbIn +: SbIn]  = stream_i.strb;
                    if (cnt_q == CntW'(N - 1)) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // Flush only when the word holds at least one lane after this accept.
                if (flush_i && state_d == FILL && (stream_i.valid || cnt_q != '0)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                // Pass-through ready keeps a full-rate input bubble-free across emission.
                stream_i.ready = stream_o.ready;
                if (stream_o.ready) begin
                    state_d = FILL;
                    buf_d   = '0;
                    strb_d  = '0;
                    cnt_d   = '0;
                    if (stream_i.valid) begin
                        buf_d[BW_IN-1:0] = stream_i.data;
                        strb_d[SbIn-1:0] = stream_i.strb;
                        cnt_d            = CntW'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FILL;
            cnt_q   <= '0;
            buf_q   <= '0;
            strb_q  <= '0;
        end else if (clear_i) begin
            state_q <= FILL;
            cnt_q   <= '0;
            buf_q   <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            strb_q  <= strb_d;
        end
    end

    assign stream_o.valid = (state_q == DRAIN);
    assign stream_o.data  = buf_q;
    assign stream_o.strb  = strb_q;

endmodule

// File: tb/tb_input_stream_packer.sv
// Self-checking bench for input_stream_packer: directed scenarios followed by random
// traffic, all compared against a queue-based word-assembly model.
module tb_input_stream_packer;

    localparam int unsigned BW_IN  = 32;
    localparam int unsigned BW_OUT = 128;
    localparam int unsigned N      = BW_OUT / BW_IN;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic flush = 1'b0;

    int checks = 0;
    int errors = 0;

    hwpe_stream_intf_stream #(.DataWidth(BW_IN))  in_if ();
    hwpe_stream_intf_stream #(.DataWidth(BW_OUT)) out_if ();

    input_stream_packer #(
        .BW_IN (BW_IN),
        .BW_OUT(BW_OUT)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .flush_i (flush),
        .stream_i(in_if),
        .stream_o(out_if)
    );

    always #5 clk = ~clk;

    // Reference model: beats gathered for the word under construction, plus the word
    // waiting to be taken downstream.
    logic [BW_IN-1:0]    lane_d[$];
    logic [BW_IN/8-1:0]  lane_s[$];
    bit                  pend;
    logic [BW_OUT-1:0]   pw;
    logic [BW_OUT/8-1:0] ps;

    task automatic chk(input string tag, input logic [BW_OUT-1:0] got,
                       input logic [BW_OUT-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        lane_d.delete();
        lane_s.delete();
        pend = 1'b0;
        pw   = '0;
        ps   = '0;
    endtask

    task automatic model_close();
        pw = '0;
        ps = '0;
        foreach (lane_d[i]) begin
            pw[i*BW_IN +: BW_IN]  = lane_d[i];
            ps[i*BW_IN/8 +: BW_IN/8] = lane_s[i];
        end
        lane_d.delete();
        lane_s.delete();
        pend = 1'b1;
    endtask

    // One clock cycle starting at a falling edge: drive, check, advance the model.
    task automatic cycle(input logic v, input logic [BW_IN-1:0] d, input logic [3:0] s,
                         input logic fl, input logic ordy, input logic clr);
        in_if.valid  = v;
        in_if.data   = d;
        in_if.strb   = s;
        flush        = fl;
        out_if.ready = ordy;
        clear        = clr;
        #1;
        chk("in_ready", {127'b0, in_if.ready}, {127'b0, (pend ? ordy : 1'b1)});
        chk("out_valid", {127'b0, out_if.valid}, {127'b0, pend});
        if (pend) begin
            chk("out_data", out_if.data, pw);
            chk("out_strb", {112'b0, out_if.strb}, {112'b0, ps});
        end
        if (clr) begin
            model_reset();
        end else if (pend) begin
            if (ordy) begin
                pend = 1'b0;
                if (v) begin
                    lane_d.push_back(d);
                    lane_s.push_back(s);
                end
            end
        end else begin
            if (v) begin
                lane_d.push_back(d);
                lane_s.push_back(s);
            end
            if (lane_d.size() == N) model_close();
            else if (fl && lane_d.size() > 0) model_close();
        end
        @(posedge clk);
        @(negedge clk);
        in_if.valid = 1'b0;
        flush       = 1'b0;
        clear       = 1'b0;
    endtask

    task automatic beat(input logic [BW_IN-1:0] d, input logic ordy);
        cycle(1'b1, d, 4'hF, 1'b0, ordy, 1'b0);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, 4'h0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.strb   = '0;
        out_if.ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", {127'b0, out_if.valid}, 128'd0);
        chk("rst_data", out_if.data, 128'd0);
        chk("rst_strb", {112'b0, out_if.strb}, 128'd0);
        chk("rst_ready", {127'b0, in_if.ready}, 128'd1);
        @(negedge clk);

        // Full rate: one word, then eight back-to-back beats.
        beat(32'h11111111, 1'b1);
        beat(32'h22222222, 1'b1);
        beat(32'h33333333, 1'b1);
        beat(32'h44444444, 1'b1);
        chk("full_word", out_if.data, 128'h44444444_33333333_22222222_11111111);
        chk("full_strb", {112'b0, out_if.strb}, 128'hFFFF);
        for (int i = 1; i <= 8; i++) beat(32'(i), 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Output stall with a pending input beat.
        for (int i = 0; i < 4; i++) beat(32'hC0DE0000 + 32'(i), 1'b0);
        for (int i = 0; i < 5; i++) beat(32'hDEAD0001, 1'b0);
        beat(32'hDEAD0001, 1'b1);
        for (int i = 0; i < 3; i++) beat(32'hBEEF0000 + 32'(i), 1'b0);
        chk("stall_lane0", {96'b0, out_if.data[31:0]}, 128'hDEAD0001);
        idle(1'b1);

        // Flush after two beats, then flush with a same-cycle third beat.
        beat(32'hA, 1'b0);
        beat(32'hB, 1'b0);
        cycle(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("flush2_data", out_if.data, 128'h00000000_00000000_0000000B_0000000A);
        chk("flush2_strb", {112'b0, out_if.strb}, 128'h00FF);
        idle(1'b1);
        beat(32'hA, 1'b0);
        beat(32'hB, 1'b0);
        cycle(1'b1, 32'hC, 4'hF, 1'b1, 1'b0, 1'b0);
        chk("flush3_strb", {112'b0, out_if.strb}, 128'h0FFF);
        idle(1'b1);

        // Empty flush is a no-op; flush during DRAIN leaves the word untouched.
        cycle(1'b0, '0, 4'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, '0, 4'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) beat(32'h5A5A0000 + 32'(i), 1'b0);
        cycle(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);

        // Asynchronous reset in the middle of a word.
        for (int i = 0; i < 3; i++) beat(32'hFEED0000 + 32'(i), 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_valid", {127'b0, out_if.valid}, 128'd0);
        chk("arst_ready", {127'b0, in_if.ready}, 128'd1);
        chk("arst_data", out_if.data, 128'd0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) beat(32'h70000000 + 32'(i), 1'b0);
        chk("arst_fresh", out_if.data, 128'h70000003_70000002_70000001_70000000);
        idle(1'b1);

        // Synchronous clear drops the partial word and the same-cycle beat.
        for (int i = 0; i < 3; i++) beat(32'hFEED0000 + 32'(i), 1'b0);
        cycle(1'b1, 32'h00000BAD, 4'hF, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) beat(32'h80000000 + 32'(i), 1'b0);
        chk("clr_fresh", out_if.data, 128'h80000003_80000002_80000001_80000000);
        idle(1'b1);

        // Mixed strobes.
        cycle(1'b1, 32'h01010101, 4'h1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h02020202, 4'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h03030303, 4'h8, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h04040404, 4'hF, 1'b0, 1'b0, 1'b0);
        chk("strb_mix", {112'b0, out_if.strb}, 128'hF801);
        chk("strb_data", out_if.data, 128'h04040404_03030303_02020202_01010101);
        idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 63) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
